// File: rtl/stage_accum.sv
// Cascade stage accumulator: sums signed leaf values per stage, compares each
// stage sum against its threshold and emits one pass/reject decision per window.
module stage_accum #(
  parameter int W_LEAF            = 14,
  parameter int STAGE_NUM         = 25,
  parameter int W_STAGE_THRESHOLD = 16,
  parameter int W_ACC             = 22,
  localparam int W_STAGE          = $clog2(STAGE_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [W_LEAF-1:0]            din_data,
  input  logic                         din_eot,
  output logic [W_STAGE-1:0]           stage_idx,
  input  logic [W_STAGE_THRESHOLD-1:0] stage_threshold,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_detect,
  output logic [W_STAGE-1:0]           res_stage
);

  localparam int W_CMP = ((W_ACC > W_STAGE_THRESHOLD) ? W_ACC : W_STAGE_THRESHOLD) + 1;
  localparam logic [W_STAGE-1:0] LAST = W_STAGE'(STAGE_NUM - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;
  state_t state;

  logic [W_ACC-1:0]        acc;
  logic [W_ACC-1:0]        leaf_ext;
  logic [W_ACC-1:0]        sum;
  logic signed [W_CMP-1:0] sum_cmp;
  logic signed [W_CMP-1:0] thr_cmp;
  logic                    pass;
  logic                    stage_last;
  logic [W_STAGE-1:0]      stage_next;
  logic                    beat;

  assign leaf_ext   = {{(W_ACC - W_LEAF){din_data[W_LEAF-1]}}, din_data};
  assign sum        = acc + leaf_ext;
  // Both operands widened one bit past the larger width so the signed compare cannot wrap.
  assign sum_cmp    = {{(W_CMP - W_ACC){sum[W_ACC-1]}}, sum};
  assign thr_cmp    = {{(W_CMP - W_STAGE_THRESHOLD){stage_threshold[W_STAGE_THRESHOLD-1]}},
                       stage_threshold};
  assign pass       = sum_cmp >= thr_cmp;
  assign stage_last = stage_idx == LAST;
  assign stage_next = stage_last ? '0 : stage_idx + W_STAGE'(1);

  assign din_ready  = (state == DRAIN) | ~res_valid | res_ready;
  assign beat       = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      acc        <= '0;
      stage_idx  <= '0;
      res_valid  <= 1'b0;
      res_detect <= 1'b0;
      res_stage  <= '0;
    end else begin
      // A result loaded below overrides this clear, giving back-to-back decisions.
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (beat) begin
        unique case (state)
          ACCUM: begin
            if (!din_eot) begin
              acc <= sum;
            end else begin
              acc       <= '0;
              stage_idx <= stage_next;
              if (!pass || stage_last) begin
                res_valid  <= 1'b1;
                res_detect <= pass;
                res_stage  <= stage_idx;
              end
              if (!pass && !stage_last) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (din_eot) begin
              stage_idx <= stage_next;
              if (stage_last) state <= ACCUM;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage_accum.sv
// Bench for stage_accum (STAGE_NUM=3): integer window model compared every cycle,
// plus hand-computed decision checks for each directed scenario.
module tb_stage_accum;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic [13:0] din_data;
  logic        din_eot;
  logic [1:0]  stage_idx;
  logic [15:0] stage_threshold;
  logic        res_valid;
  logic        res_ready;
  logic        res_detect;
  logic [1:0]  res_stage;

  int tests = 0;
  int fails = 0;
  int thr_rom [4];
  int log_det [$];
  int log_stg [$];

  always #5 clk = ~clk;

  assign stage_threshold = 16'(thr_rom[stage_idx]);

  stage_accum #(.STAGE_NUM(S)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_eot(din_eot),
    .stage_idx(stage_idx), .stage_threshold(stage_threshold),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_detect(res_detect), .res_stage(res_stage)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window model: integer running sum, position within the window, and whether
  // the window was already rejected (remaining beats are discarded).
  int m_sum, m_stage, m_rv, m_det, m_rs, m_init = 0;
  bit m_rejected;
  always @(posedge clk) begin
    bit rdy;
    int leaf;
    if (rst) begin
      m_sum = 0; m_stage = 0; m_rejected = 0; m_rv = 0; m_det = 0; m_rs = 0; m_init = 1;
    end else if (m_init == 1) begin
      rdy = m_rejected || (m_rv == 0) || res_ready;
      if (m_rv == 1 && res_ready) m_rv = 0;
      if (din_valid && rdy) begin
        leaf = $signed(din_data);
        if (!m_rejected) m_sum = m_sum + leaf;
        if (din_eot) begin
          if (!m_rejected) begin
            if (m_sum < thr_rom[m_stage]) begin
              m_rv = 1; m_det = 0; m_rs = m_stage;
              m_rejected = (m_stage != S - 1);
            end else if (m_stage == S - 1) begin
              m_rv = 1; m_det = 1; m_rs = S - 1;
            end
          end else if (m_stage == S - 1) begin
            m_rejected = 0;
          end
          m_sum = 0;
          m_stage = (m_stage == S - 1) ? 0 : m_stage + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init == 1) begin
      check("din_ready", int'(din_ready), (m_rejected || m_rv == 0 || res_ready) ? 1 : 0);
      check("stage_idx", int'(stage_idx), m_stage);
      check("res_valid", int'(res_valid), m_rv);
      check("res_detect", int'(res_detect), m_det);
      check("res_stage", int'(res_stage), m_rs);
      if (res_valid && res_ready) begin
        log_det.push_back(int'(res_detect));
        log_stg.push_back(int'(res_stage));
      end
    end
  end

  task automatic send(input int v, input bit e);
    int n = 0;
    bit acc = 0;
    din_valid = 1'b1; din_data = 14'(v); din_eot = e;
    do begin
      @(negedge clk); acc = din_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 0, 1);
    din_valid = 1'b0; din_eot = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pop(input string name, input int det, input int stg);
    if (log_det.size() == 0) begin
      check({name, "_present"}, 0, 1);
    end else begin
      check({name, "_det"}, log_det.pop_front(), det);
      check({name, "_stg"}, log_stg.pop_front(), stg);
    end
  endtask

  task automatic set_thr(input int a, input int b, input int c);
    thr_rom[0] = a; thr_rom[1] = b; thr_rom[2] = c; thr_rom[3] = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din_data = '0; din_eot = 1'b0; res_ready = 1'b1;
    set_thr(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_stage_idx", int'(stage_idx), 0);
    check("rst_res_stage", int'(res_stage), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: sums 10,5,0 against 8,5,-1 -> detect one cycle after the final eot
    set_thr(8, 5, -1);
    send(6, 0); send(4, 1); send(2, 0); send(3, 1); send(3, 0); send(-3, 1);
    @(negedge clk);
    check("t1_latency_valid", int'(res_valid), 1);
    check("t1_latency_det", int'(res_detect), 1);
    idle(2);
    check_pop("t1", 1, 2);

    // T2: -3+1 < 0 at stage 0; four beats drained
    set_thr(0, 0, 0);
    send(-3, 0); send(1, 1);
    send(5, 0); send(5, 1); send(7, 0); send(7, 1);
    @(negedge clk);
    check("t2_stage_back", int'(stage_idx), 0);
    idle(2);
    check_pop("t2", 0, 0);
    check("t2_single_result", log_det.size(), 0);

    // T3a: -7 vs -7 passes, -8 vs -7 fails at stage 1
    set_thr(-7, -7, -7);
    send(-4, 0); send(-3, 1); send(-5, 0); send(-3, 1); send(9, 0); send(9, 1);
    idle(2);
    check_pop("t3a", 0, 1);
    // T3b: extreme leaf codes 0x1FFF and 0x2000
    set_thr(-1, 16382, -16384);
    send('h1FFF, 0); send('h2000, 1);
    send('h1FFF, 0); send('h1FFF, 1);
    send('h2000, 0); send('h2000, 1);
    idle(2);
    check_pop("t3b", 1, 2);

    // T4: result held unconsumed stalls the next window without losing beats
    set_thr(0, 0, 0);
    res_ready = 1'b0;
    send(1, 0); send(1, 1); send(1, 0); send(1, 1); send(1, 0); send(1, 1);
    fork
      begin
        send(2, 0); send(2, 1); send(-1, 0); send(-1, 1); send(4, 0); send(4, 1);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("t4_stall", int'(din_ready), 0);
          check("t4_stage_frozen", int'(stage_idx), 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    idle(2);
    check_pop("t4_first", 1, 2);
    check_pop("t4_second", 0, 1);

    // T5: handshake and a new deciding eot in the same cycle
    send(1, 1); send(1, 1); send(1, 1);
    res_ready = 1'b0;
    fork
      send(-2, 1);
      begin
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid_held", int'(res_valid), 1);
        check("t5_new_det", int'(res_detect), 0);
        check("t5_new_stg", int'(res_stage), 0);
      end
    join
    send(0, 1); send(0, 1);
    idle(2);
    check_pop("t5_old", 1, 2);
    check_pop("t5_new", 0, 0);

    // T6: reset mid-DRAIN drops the pending result; reset mid-stage clears acc
    res_ready = 1'b0;
    send(-1, 1); send(3, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t6_stage_idx", int'(stage_idx), 0);
    check("t6_res_valid", int'(res_valid), 0);
    check("t6_din_ready", int'(din_ready), 1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    send(5, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("t6_dropped", log_det.size(), 0);
    send(-1, 1); send(0, 1); send(0, 1);
    idle(2);
    check_pop("t6_clean", 0, 0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
